// File: rtl/uart_tx_msg_sequencer.sv
// rtl/uart_tx_msg_sequencer.sv - feeds a fixed-length message byte by byte into a UART transmitter
module uart_tx_msg_sequencer #(
  parameter int DATA_BIT       = 8,
  parameter int MSG_LEN        = 5,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2000000,
  localparam int IDX_W         = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [MSG_LEN*DATA_BIT-1:0] i_msg,
  input  logic                        i_tx_done,
  output logic                        o_tx_data_avail,
  output logic [DATA_BIT-1:0]         o_tx_din,
  output logic                        o_busy,
  output logic [IDX_W-1:0]            o_byte_idx,
  output logic                        o_msg_done,
  output logic                        o_error
);

  // One counter serves both the inter-byte gap and the done timeout.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GAP,
    S_FINISH
  } state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  sync_q;
  logic                        start_prev_q;
  logic                        start_rise;
  logic [MSG_LEN*DATA_BIT-1:0] msg_q, msg_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [DATA_BIT-1:0]         din_q, din_d;
  logic                        avail_q, avail_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic [DATA_BIT-1:0]         cur_byte;
  logic                        last_byte;
  logic                        timed_out;

  assign start_rise = sync_q[1] & ~start_prev_q;
  assign cur_byte   = msg_q[int'(idx_q) * DATA_BIT +: DATA_BIT];
  assign last_byte  = (idx_q == IDX_LAST);
  assign timed_out  = (cnt_q == TO_LAST);

  // State register, start synchronizer and registered datapath/outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b00;
      start_prev_q <= 1'b0;
      msg_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      din_q        <= '0;
      avail_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], i_start};
      start_prev_q <= sync_q[1];
      msg_q        <= msg_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      din_q        <= din_d;
      avail_q      <= avail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next-state decode; a done arriving with timeout expiry takes priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_rise) state_d = S_SEND;
      S_SEND:   state_d = S_WAIT;
      S_WAIT: begin
        if (i_tx_done) begin
          if (last_byte)    state_d = S_FINISH;
          else if (HAS_GAP) state_d = S_GAP;
          else              state_d = S_SEND;
        end else if (timed_out) begin
          state_d = S_IDLE;
        end
      end
      S_GAP:    if (cnt_q == GAP_LAST) state_d = S_SEND;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; outputs are registered so they lag the state by one clock.
  always_comb begin
    msg_d   = msg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    avail_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          msg_d  = i_msg;
          idx_d  = '0;
          err_d  = 1'b0;
          busy_d = 1'b1;
        end
      end
      S_SEND: begin
        din_d   = cur_byte;
        avail_d = 1'b1;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          cnt_d = '0;
          if (last_byte) done_d = 1'b1;
          else           idx_d  = idx_q + 1'b1;
        end else if (timed_out) begin
          err_d  = 1'b1;
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP:    cnt_d  = cnt_q + 1'b1;
      S_FINISH: busy_d = 1'b0;
      default:  busy_d = 1'b0;
    endcase
  end

  assign o_tx_data_avail = avail_q;
  assign o_tx_din        = din_q;
  assign o_busy          = busy_q;
  assign o_byte_idx      = idx_q;
  assign o_msg_done      = done_q;
  assign o_error         = err_q;

endmodule

// File: tb/tb_uart_tx_msg_sequencer.sv
// tb/tb_uart_tx_msg_sequencer.sv - directed self-checking bench for uart_tx_msg_sequencer
module tb_uart_tx_msg_sequencer;

  localparam int DB  = 8;
  localparam int ML  = 5;
  localparam int GAP = 4;
  localparam int TO  = 50;
  localparam int RSP = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, start, tx_done;
  logic [ML*DB-1:0] msg;
  logic            avail, busy, mdone, err;
  logic [7:0]      din;
  logic [2:0]      idx;

  logic            start1, tx_done1;
  logic [7:0]      msg1;
  logic            avail1, busy1, mdone1, err1;
  logic [7:0]      din1;
  logic [0:0]      idx1;

  uart_tx_msg_sequencer #(.DATA_BIT(DB), .MSG_LEN(ML), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_msg(msg), .i_tx_done(tx_done),
    .o_tx_data_avail(avail), .o_tx_din(din), .o_busy(busy), .o_byte_idx(idx),
    .o_msg_done(mdone), .o_error(err)
  );

  uart_tx_msg_sequencer #(.DATA_BIT(DB), .MSG_LEN(1), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_msg(msg1), .i_tx_done(tx_done1),
    .o_tx_data_avail(avail1), .o_tx_din(din1), .o_busy(busy1), .o_byte_idx(idx1),
    .o_msg_done(mdone1), .o_error(err1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples 1ns after each rising edge; cyc is the index of the current cycle.
  int         cyc = 0;
  int         av_cyc[$];
  logic [7:0] av_din[$];
  int         md_cyc[$];
  int         busy_drop = 0;
  bit         in_msg = 0;
  int         err_rise = -1;
  logic       err_prev = 1'b0;
  int         av1_cyc[$];
  logic [7:0] av1_din[$];
  int         md1_cyc[$];
  int         done1_cyc[$];
  int         idx1_max = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (avail === 1'b1) begin av_cyc.push_back(cyc); av_din.push_back(din); in_msg = 1; end
      if (in_msg && busy !== 1'b1) busy_drop++;
      if (mdone === 1'b1) begin md_cyc.push_back(cyc); in_msg = 0; end
      if (err === 1'b1 && err_prev !== 1'b1 && err_rise < 0) err_rise = cyc;
      err_prev = err;
      if (avail1 === 1'b1) begin av1_cyc.push_back(cyc); av1_din.push_back(din1); end
      if (mdone1 === 1'b1) md1_cyc.push_back(cyc);
      if (int'(idx1) > idx1_max) idx1_max = int'(idx1);
    end
  end

  // Transmitter models: done RSP cycles after a request (dut), 3 cycles after (dut1).
  bit model_en = 1;
  int rcnt = 0;
  int rcnt1 = 0;
  initial begin
    tx_done = 1'b0;
    tx_done1 = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!rst_n) rcnt = 0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0 && model_en) tx_done = 1'b1;
      end
      if (avail === 1'b1) rcnt = RSP;
      tx_done1 = 1'b0;
      if (rcnt1 > 0) begin
        rcnt1--;
        if (rcnt1 == 0) begin tx_done1 = 1'b1; done1_cyc.push_back(cyc); end
      end
      if (avail1 === 1'b1) rcnt1 = 3;
    end
  end

  task automatic clear_log();
    av_cyc.delete(); av_din.delete(); md_cyc.delete();
    av1_cyc.delete(); av1_din.delete(); md1_cyc.delete(); done1_cyc.delete();
    busy_drop = 0; in_msg = 0; err_rise = -1; idx1_max = 0;
  endtask

  task automatic pulse_start(input bit which, input int hold, output int c0);
    @(negedge clk);
    if (which) start1 = 1'b1; else start = 1'b1;
    c0 = cyc;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_avail(input int n, input int budget);
    int i = 0;
    while (av_cyc.size() < n && i < budget) begin @(negedge clk); i++; end
    check_eq("avail_seen", 64'(av_cyc.size() >= n), 64'd1);
  endtask

  task automatic wait_md(input int n, input int budget);
    int i = 0;
    while (md_cyc.size() < n && i < budget) begin @(negedge clk); i++; end
    check_eq("msg_done_seen", 64'(md_cyc.size() >= n), 64'd1);
  endtask

  function automatic logic [7:0] din_at(input int i);
    return (i < av_din.size()) ? av_din[i] : 8'hxx;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < av_cyc.size()) ? av_cyc[i] : -1000;
  endfunction

  logic [7:0] hello[5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
  int c0;
  int dummy;

  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    msg = 40'h6F6C6C6548; msg1 = 8'h5A;

    // Reset held while start toggles
    for (int i = 0; i < 6; i++) begin @(negedge clk); start = ~start; start1 = ~start1; end
    start = 1'b0; start1 = 1'b0;
    #1;
    check_eq("rst_avail", 64'(avail), 64'd0);
    check_eq("rst_din", 64'(din), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_idx", 64'(idx), 64'd0);
    check_eq("rst_msg_done", 64'(mdone), 64'd0);
    check_eq("rst_error", 64'(err), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("idle_no_req", 64'(av_cyc.size() + av1_cyc.size()), 64'd0);

    // Full message, latency, snapshot and busy rejection
    clear_log();
    pulse_start(1'b0, 3, c0);
    wait_avail(1, 20);
    check_eq("start_latency", 64'(cyc_at(0) - c0), 64'd4);
    msg = 40'h1122334455;
    wait_avail(2, 100);
    pulse_start(1'b0, 2, dummy);
    wait_md(1, 400);
    repeat (60) @(negedge clk);
    check_eq("hello_count", 64'(av_cyc.size()), 64'd5);
    for (int i = 0; i < 5; i++) check_eq($sformatf("hello_byte%0d", i), 64'(din_at(i)), 64'(hello[i]));
    for (int i = 1; i < 5; i++) check_eq($sformatf("spacing%0d", i), 64'(cyc_at(i) - cyc_at(i - 1)), 64'd26);
    check_eq("msg_done_count", 64'(md_cyc.size()), 64'd1);
    check_eq("msg_done_cycle", 64'(md_cyc.size() > 0 ? md_cyc[0] - cyc_at(4) : -1), 64'd21);
    check_eq("busy_through_msg", 64'(busy_drop), 64'd0);
    check_eq("final_idx", 64'(idx), 64'd4);
    check_eq("busy_after_msg", 64'(busy), 64'd0);
    check_eq("din_held_idle", 64'(din), 64'h6F);
    msg = 40'h6F6C6C6548;

    // Timeout with no done from the transmitter
    clear_log();
    model_en = 0;
    pulse_start(1'b0, 2, c0);
    for (int i = 0; i < 120 && err_rise < 0; i++) @(negedge clk);
    check_eq("timeout_delay", 64'(err_rise - cyc_at(0)), 64'd50);
    check_eq("timeout_busy", 64'(busy), 64'd0);
    check_eq("timeout_no_done", 64'(md_cyc.size()), 64'd0);
    check_eq("timeout_one_req", 64'(av_cyc.size()), 64'd1);
    model_en = 1;
    repeat (5) @(negedge clk);
    clear_log();
    pulse_start(1'b0, 2, c0);
    wait_avail(1, 20);
    check_eq("error_cleared", 64'(err), 64'd0);
    check_eq("resend_byte0", 64'(din_at(0)), 64'h48);
    wait_md(1, 400);
    repeat (5) @(negedge clk);

    // Reset during the gap after the second byte
    clear_log();
    pulse_start(1'b0, 2, c0);
    wait_avail(2, 200);
    repeat (22) @(negedge clk);
    check_eq("gap_idx", 64'(idx), 64'd2);
    check_eq("gap_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_idx", 64'(idx), 64'd0);
    check_eq("midrst_din", 64'(din), 64'd0);
    check_eq("midrst_avail", 64'(avail), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    clear_log();
    pulse_start(1'b0, 2, c0);
    wait_avail(1, 20);
    check_eq("post_rst_byte0", 64'(din_at(0)), 64'h48);
    wait_md(1, 400);

    // Single-byte message, no gap
    clear_log();
    pulse_start(1'b1, 2, c0);
    for (int i = 0; i < 10 && av1_cyc.size() == 0; i++) @(negedge clk);
    msg1 = 8'hA5;
    for (int i = 0; i < 40 && md1_cyc.size() == 0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check_eq("one_req_count", 64'(av1_cyc.size()), 64'd1);
    check_eq("one_din", 64'(av1_din.size() > 0 ? av1_din[0] : 8'hxx), 64'h5A);
    check_eq("one_done_count", 64'(md1_cyc.size()), 64'd1);
    check_eq("one_done_lat", 64'((md1_cyc.size() > 0 && done1_cyc.size() > 0) ? md1_cyc[0] - done1_cyc[0] : -1), 64'd1);
    check_eq("one_idx_max", 64'(idx1_max), 64'd0);
    check_eq("one_busy_end", 64'(busy1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_msg_sequencer.md
Name: uart_tx_msg_sequencer

Overview:
Upstream feeder for the UART transmitter. On a start request it snapshots a fixed-length message and presents the bytes to the transmitter one at a time. Each byte uses the transmitter's data-available / done handshake, with a programmable inter-byte gap and a per-byte timeout. It replaces the hard-wired single-byte transmit request in the UART controller top level and drives the transmitter's data-available and data inputs directly.

Parameters:
DATA_BIT, 8, width of each message byte.
MSG_LEN, 5, number of bytes per message (≥1).
GAP_CYCLES, 16, idle clocks between a byte's done and the next byte's request (0 = no gap).
TIMEOUT_CYCLES, 2000000, max clocks to wait for done after a request before aborting (≥2).

Ports:
i_clk  in  1  system clock.
i_rst_n  in  1  asynchronous active-low reset.
i_start  in  1  asynchronous start request (e.g. push button, active-high after top-level inversion).
i_msg  in  MSG_LEN*DATA_BIT  message; byte 0 = bits [DATA_BIT-1:0], sent first.
i_tx_done  in  1  one-cycle pulse from transmitter when the current byte has finished.
o_tx_data_avail  out  1  one-cycle request pulse to transmitter.
o_tx_din  out  DATA_BIT  byte being sent.
o_busy  out  1  high from accepted start until return to IDLE.
o_byte_idx  out  $clog2(MSG_LEN) (min 1)  index of current byte.
o_msg_done  out  1  one-cycle pulse when the last byte's done is received.
o_error  out  1  sticky timeout flag.

Behaviour:
- Reset: async on i_rst_n low. All outputs 0, state IDLE, synchronizer flops 0, counters 0. Reset mid-message aborts immediately. No request is issued until a fresh start edge arrives after release.
- i_start passes through a 2-flop synchronizer; start_rise = sync2 & ~sync2_d.
- A start_rise is accepted only in IDLE. Rises in any other state are discarded, not queued.
- Latency: if i_start is high at clk edge k (and low before), o_tx_data_avail is high in the cycle after edge k+3.
- States:
  - IDLE: on accepted start, snapshot i_msg into internal register, idx←0, o_error←0, o_busy←1, go SEND.
  - SEND: o_tx_din←msg[idx], o_tx_data_avail=1 for exactly this cycle, timeout counter←0, go WAIT_DONE. An i_tx_done in this cycle is ignored.
  - WAIT_DONE: o_tx_din held stable. On i_tx_done: if idx==MSG_LEN-1 go FINISH; else idx←idx+1 and go GAP (or SEND directly if GAP_CYCLES==0). If TIMEOUT_CYCLES clocks elapse with no done: o_error←1, o_busy←0, go IDLE (no o_msg_done).
  - GAP: count GAP_CYCLES clocks, then go SEND. i_tx_done here is ignored.
  - FINISH: o_msg_done=1 for one cycle, o_busy←0, go IDLE.
- o_tx_din holds its last value in IDLE (no glitch back to 0 after the first message).
- Changes to i_msg after acceptance have no effect on the message in flight.
- Byte spacing: consecutive o_tx_data_avail pulses are separated by at least GAP_CYCLES+2 clocks.
- o_byte_idx never exceeds MSG_LEN-1. No wrap occurs within a message.
- Simultaneous done and timeout expiry in the same cycle: done wins.

Test Plan:
- Reset/idle: hold i_rst_n=0 while toggling i_start → all outputs 0. Release reset with i_start=0 → no o_tx_data_avail for 100 clocks.
- Full message: i_msg="Hello" (0x6F6C6C6548), GAP_CYCLES=4. Transmitter model returns done 20 clocks after each request → o_tx_din sequence 0x48,0x65,0x6C,0x6C,0x6F; 5 avail pulses spaced 26 clocks apart; one o_msg_done after the 5th done; o_busy high throughout.
- Start latency and busy rejection: i_start rises at edge k → first avail in the cycle after k+3. Pulse i_start again mid-message → no extra bytes, no second message.
- Timeout: TIMEOUT_CYCLES=50, model never returns done → o_error=1 and o_busy=0 exactly 50 clocks after the first request, no o_msg_done. Next start clears o_error and resends byte 0x48.
- Reset mid-operation: assert i_rst_n=0 during GAP after byte 2 → outputs 0 immediately. After release, a new start sends from byte 0.
- Snapshot and edge cases: change i_msg after acceptance → original bytes sent. MSG_LEN=1 with GAP_CYCLES=0 → single request, o_msg_done one cycle after done, o_byte_idx stays 0.
